// File: rtl/miner_job_if.sv
// Handshake bundle between the job controller, the SPI host side and the hashing cores.
interface miner_job_if #(
  parameter int NUM_CORES = 4,
  parameter int NONCE_W   = 32
);
  logic                 request_job;
  logic                 job_received;
  logic                 job_abort;
  logic                 core_start;
  logic [NONCE_W-1:0]   core_nonce_base;
  logic [NUM_CORES-1:0] core_done;
  logic [NUM_CORES-1:0] core_found;
  logic                 result_valid;
  logic                 result_ready;
  logic                 result_found;
  logic [NONCE_W-1:0]   result_nonce;
  logic [2:0]           fsm_state;

  modport master (
    output request_job, core_start, core_nonce_base,
           result_valid, result_found, result_nonce, fsm_state,
    input  job_received, job_abort, core_done, core_found, result_ready
  );

  modport slave (
    input  request_job, core_start, core_nonce_base,
           result_valid, result_found, result_nonce, fsm_state,
    output job_received, job_abort, core_done, core_found, result_ready
  );
endinterface

// File: rtl/miner_job_controller.sv
// Job-control FSM: fetch a job with timeout/retry, sweep nonces over NUM_CORES cores in
// lock-step batches, and hand the found/exhausted result to the consumer.
module miner_job_controller #(
  parameter int NUM_CORES      = 4,
  parameter int NONCE_W        = 32,
  parameter int TIMEOUT_CYCLES = 1_000_000
) (
  input  logic         clk,
  input  logic         rst,
  miner_job_if.master  bus
);
  localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam int IDX_W = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1;
  localparam logic [CNT_W-1:0]   CNT_MAX   = CNT_W'(TIMEOUT_CYCLES - 1);
  // Bases are multiples of NUM_CORES, so 2^NONCE_W - NUM_CORES is ~(NUM_CORES-1).
  localparam logic [NONCE_W-1:0] LAST_BASE = ~NONCE_W'(NUM_CORES - 1);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_REQUEST = 3'd1,
    S_WAIT    = 3'd2,
    S_START   = 3'd3,
    S_COMPUTE = 3'd4,
    S_SEND    = 3'd5
  } state_t;

  state_t               state, state_n;
  logic [NONCE_W-1:0]   base, base_n;
  logic [CNT_W-1:0]     cnt, cnt_n;
  logic [NUM_CORES-1:0] done_seen, done_seen_n, found_seen, found_seen_n, hits;
  logic                 res_found, res_found_n, done_all;
  logic [NONCE_W-1:0]   res_nonce, res_nonce_n;
  logic [IDX_W-1:0]     hit_idx;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= S_IDLE;
      base       <= '0;
      cnt        <= '0;
      done_seen  <= '0;
      found_seen <= '0;
      res_found  <= 1'b0;
      res_nonce  <= '0;
    end else begin
      state      <= state_n;
      base       <= base_n;
      cnt        <= cnt_n;
      done_seen  <= done_seen_n;
      found_seen <= found_seen_n;
      res_found  <= res_found_n;
      res_nonce  <= res_nonce_n;
    end
  end

  always_comb begin
    state_n      = state;
    base_n       = base;
    cnt_n        = cnt;
    done_seen_n  = done_seen;
    found_seen_n = found_seen;
    res_found_n  = res_found;
    res_nonce_n  = res_nonce;
    // This cycle's dones/founds count toward batch completion.
    done_all = &(done_seen | bus.core_done);
    hits     = found_seen | (bus.core_found & bus.core_done);
    hit_idx  = '0;
    for (int i = NUM_CORES - 1; i >= 0; i--)
      if (hits[i]) hit_idx = IDX_W'(i);

    case (state)
      S_IDLE:    state_n = S_REQUEST;
      S_REQUEST: begin
        cnt_n   = '0;
        state_n = S_WAIT;
      end
      S_WAIT: begin
        if (bus.job_received) begin
          base_n  = '0;
          state_n = S_START;
        end else begin
          cnt_n = cnt + 1'b1;
          if (cnt == CNT_MAX) state_n = S_REQUEST;
        end
      end
      S_START: begin
        if (bus.job_abort) state_n = S_REQUEST;
        else begin
          done_seen_n  = '0;
          found_seen_n = '0;
          state_n      = S_COMPUTE;
        end
      end
      S_COMPUTE: begin
        if (bus.job_abort) state_n = S_REQUEST;
        else begin
          done_seen_n  = done_seen | bus.core_done;
          found_seen_n = hits;
          if (done_all) begin
            if (|hits) begin
              res_found_n = 1'b1;
              res_nonce_n = base + NONCE_W'(hit_idx);
              state_n     = S_SEND;
            end else if (base == LAST_BASE) begin
              res_found_n = 1'b0;
              res_nonce_n = '1;
              state_n     = S_SEND;
            end else begin
              base_n  = base + NONCE_W'(NUM_CORES);
              state_n = S_START;
            end
          end
        end
      end
      S_SEND:  if (bus.result_ready) state_n = S_REQUEST;
      default: state_n = S_IDLE;
    endcase
  end

  assign bus.request_job     = (state == S_REQUEST);
  assign bus.core_start      = (state == S_START);
  assign bus.result_valid    = (state == S_SEND);
  assign bus.core_nonce_base = base;
  assign bus.result_found    = res_found;
  assign bus.result_nonce    = res_nonce;
  assign bus.fsm_state       = state;
endmodule
